rr_arbiter_15: RTL and testbench
================================

// Module: rr_arbiter_15
// PURPOSE
//  Registered round-robin arbiter: up to 15 requesters share one resource (bus/port).
//  Produces a one-hot grant vector that feeds the 15-to-4 encoder downstream.
//  The encoder turns the grant into a 4-bit owner code; code 0 = no owner.
//  Grant is held while the owner keeps requesting, bounded by a hold timeout.
// PARAMETERS
//  N         15  number of requesters; fixed at 15 to match the downstream encoder
//  MAX_HOLD  16  max consecutive cycles one owner may hold grant (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req        in   N   request per requester, level-sensitive, bit k = requester k
//  grant      out  N   registered one-hot grant; all-zero = no owner
//  busy       out  1   registered; 1 iff grant != 0
//  timeout    out  1   registered one-cycle pulse; owner lost grant by hold limit
// BEHAVIOUR
//  Reset (async assert, sync deassert by user): grant=0, busy=0, timeout=0,
//    state=IDLE, ptr=0, hold_cnt=0.
//  State: IDLE (no owner) / OWNED (grant one-hot, owner index own).
//  Arbitration fn pick(mask): first set bit of req&mask scanning ptr, ptr+1, ... N-1,
//    0, ... ptr-1 (wrap mod N); returns one-hot, or 0 if none.
//  IDLE: if |req -> next edge grant=pick(all ones), state=OWNED, hold_cnt=1,
//    ptr=(winner+1) mod N. Latency req->grant = 1 cycle. Else stay IDLE.
//  OWNED, req[own]=1 and hold_cnt<MAX_HOLD: hold grant, hold_cnt++.
//  OWNED, req[own]=0 (release): same edge re-arbitrate pick(all ones) over current req
//    (no bubble); if none -> IDLE, grant=0.
//  OWNED, req[own]=1 and hold_cnt==MAX_HOLD (timeout): re-arbitrate with own masked out;
//    timeout=1 for one cycle. If no other requester, owner regrants (hold_cnt=1), and
//    timeout still pulses.
//  Any new grant: hold_cnt=1, ptr=(new winner+1) mod N. ptr unchanged while holding.
//  grant never multi-hot; grant changes only on rising clk edge or async reset.
//  Requests arriving while OWNED are not latched; they must remain asserted to win.
//  hold_cnt width $clog2(MAX_HOLD+1); saturates, never wraps.
//  Reset mid-grant: grant drops to 0 immediately (async); ptr returns to 0.
//  req==0 in all states -> IDLE within 1 cycle; timeout low.
// STRUCTURE
//  Shared package cpu_arb_pkg: localparam ARB_N=15, typedef logic [ARB_N-1:0]
//    arb_vec_t, typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t.
//  One sub-module natural: rr_pick_15 (combinational: req, mask, ptr -> one-hot,
//    implemented as double-width rotate + priority find).
//  Top: state/ptr/hold_cnt/grant registers plus next-state logic.
// TESTING
//  T1 reset: rst_n=0 with req=15'h7FFF -> grant=0, busy=0, timeout=0; release -> grant=0x0001 next cycle.
//  T2 rotation: req=0x7FFF, each owner drops req 1 cycle after grant, then reasserts -> grants
//    0x0001,0x0002,...,0x4000,0x0001 (wrap), no idle cycles between.
//  T3 timeout: MAX_HOLD=4, req=0x0006 held -> bit1 granted 4 cycles, timeout pulse, bit2 granted.
//  T4 lone timeout: req=0x0100 held, MAX_HOLD=4 -> grant stays 0x0100, timeout pulses every 4 cycles.
//  T5 release to idle: owner 0x0010 drops req with req=0 -> grant=0, busy=0 next cycle.
//  T6 async reset mid-grant: rst_n low between edges while grant=0x0400 -> grant=0 immediately;
//    after release with req=0x0400|0x0001 -> grant=0x0001 (ptr reset to 0).
//  All tests: assert $onehot0(grant), busy==|grant, encoder code matches owner index+1.

Source files
------------

// File: rtl/cpu_arb_pkg.sv
// Shared types for the 15-requester round-robin arbiter and its owner-code encoder.
package cpu_arb_pkg;
  localparam int ARB_N  = 15;
  localparam int ARB_IW = 4;

  typedef logic [ARB_N-1:0] arb_vec_t;
  typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;

  // Owner code as seen by the downstream encoder: 0 = no owner, else index+1.
  function automatic logic [ARB_IW-1:0] arb_code(input arb_vec_t g);
    logic [ARB_IW-1:0] c;
    c = '0;
    for (int i = 0; i < ARB_N; i++) begin
      if (g[i]) c = ARB_IW'(i + 1);
    end
    return c;
  endfunction

  function automatic logic [ARB_IW-1:0] arb_next_idx(input logic [ARB_IW-1:0] idx);
    return (idx == ARB_IW'(ARB_N - 1)) ? '0 : idx + 1'b1;
  endfunction
endpackage

// File: rtl/rr_arbiter_15_pick.sv
// Combinational round-robin pick: first set bit of req&mask starting at ptr, wrapping.
module rr_pick_15
  import cpu_arb_pkg::*;
(
  input  arb_vec_t          req,
  input  arb_vec_t          mask,
  input  logic [ARB_IW-1:0] ptr,
  output arb_vec_t          grant,
  output logic [ARB_IW-1:0] idx,
  output logic              found
);
  logic [2*ARB_N-1:0] dbl;
  arb_vec_t           rot;
  logic [ARB_IW-1:0]  off;
  logic [ARB_IW:0]    sum;
  logic [ARB_IW:0]    wrap;

  always_comb begin
    // Rotating the doubled vector puts requester ptr at bit 0.
    dbl   = {req & mask, req & mask} >> ptr;
    rot   = dbl[ARB_N-1:0];
    found = 1'b0;
    off   = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = ARB_IW'(i);
      end
    end
    sum   = {1'b0, off} + {1'b0, ptr};
    wrap  = sum - (ARB_IW+1)'(ARB_N);
    idx   = (sum >= (ARB_IW+1)'(ARB_N)) ? wrap[ARB_IW-1:0] : sum[ARB_IW-1:0];
    grant = found ? (arb_vec_t'(1) << idx) : '0;
  end
endmodule

// File: rtl/rr_arbiter_15.sv
// Registered round-robin arbiter for 15 requesters with bounded grant hold.
module rr_arbiter_15
  import cpu_arb_pkg::*;
#(
  parameter int N        = 15,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  arb_state_t        state_q, state_d;
  arb_vec_t          grant_q, grant_d;
  logic [ARB_IW-1:0] own_q, own_d;
  logic [ARB_IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic              busy_q;

  arb_vec_t          req_v, mask, win_oh;
  logic [ARB_IW-1:0] win_idx;
  logic              win_found, own_req, hold_expired, take_win;

  assign req_v        = req;
  assign own_req      = |(req_v & grant_q);
  assign hold_expired = (hold_q >= HOLD_MAX);
  assign mask         = (state_q == ARB_OWNED && own_req && hold_expired) ? ~grant_q : '1;

  rr_pick_15 u_pick (
    .req  (req_v),
    .mask (mask),
    .ptr  (ptr_q),
    .grant(win_oh),
    .idx  (win_idx),
    .found(win_found)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    take_win  = 1'b0;
    case (state_q)
      ARB_IDLE: take_win = win_found;
      ARB_OWNED: begin
        if (own_req && !hold_expired) begin
          hold_d = hold_q + 1'b1;
        end else if (own_req) begin
          timeout_d = 1'b1;
          if (win_found) begin
            take_win = 1'b1;
          end else begin
            // Lone requester at its limit: regrant itself, pulse still fires.
            hold_d = HW'(1);
            ptr_d  = arb_next_idx(own_q);
          end
        end else if (win_found) begin
          take_win = 1'b1;
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
          hold_d  = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (take_win) begin
      state_d = ARB_OWNED;
      grant_d = win_oh;
      own_d   = win_idx;
      hold_d  = HW'(1);
      ptr_d   = arb_next_idx(win_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      own_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      own_q     <= own_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      busy_q    <= |grant_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_15.sv
// Scoreboard bench for rr_arbiter_15 (MAX_HOLD=4): directed vectors, negedge monitor.
module tb_rr_arbiter_15;
  import cpu_arb_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  arb_vec_t req;
  arb_vec_t grant;
  logic     busy;
  logic     timeout;

  rr_arbiter_15 #(.N(15), .MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       due;
    arb_vec_t g;
    logic     to;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] ref_code(input arb_vec_t g);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 15; i++) if (g[i]) c = 4'(i + 1);
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, want);
    end
  endtask

  task automatic push(input arb_vec_t eg, input logic et);
    exp_t e;
    e.due = cyc + 1;
    e.g   = eg;
    e.to  = et;
    sb.push_back(e);
  endtask

  task automatic step(input arb_vec_t r, input arb_vec_t eg, input logic et);
    @(posedge clk);
    #2;
    req = r;
    push(eg, et);
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("onehot0", 32'($onehot0(grant)), 32'd1);
    check("busy_eq_or", 32'(busy), 32'(|grant));
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      check("missed_slot", 32'(e.due), 32'(cyc));
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("grant", 32'(grant), 32'(e.g));
      check("busy", 32'(busy), 32'(|e.g));
      check("timeout", 32'(timeout), 32'(e.to));
      check("owner_code", 32'(arb_code(grant)), 32'(ref_code(e.g)));
    end
  end

  initial begin
    arb_vec_t one;
    one   = 15'h0001;
    rst_n = 1'b1;
    req   = 15'h7FFF;
    #1 rst_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    step(15'h7FFF, 15'h0000, 1'b0);
    step(15'h7FFF, 15'h0000, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    req   = 15'h7FFF;
    push(15'h0001, 1'b0);

    // Rotation: each owner drops its request right after being granted.
    for (int k = 0; k < 15; k++)
      step(15'h7FFF & ~(one << k), one << ((k + 1) % 15), 1'b0);

    // Two requesters held: hold limit hands over in both directions.
    step(15'h0006, 15'h0002, 1'b0);
    for (int k = 0; k < 3; k++) step(15'h0006, 15'h0002, 1'b0);
    step(15'h0006, 15'h0004, 1'b1);
    for (int k = 0; k < 3; k++) step(15'h0006, 15'h0004, 1'b0);
    step(15'h0006, 15'h0002, 1'b1);

    // Lone requester at the limit keeps the grant, timeout still pulses.
    step(15'h0100, 15'h0100, 1'b0);
    for (int k = 0; k < 3; k++) step(15'h0100, 15'h0100, 1'b0);
    step(15'h0100, 15'h0100, 1'b1);
    for (int k = 0; k < 3; k++) step(15'h0100, 15'h0100, 1'b0);
    step(15'h0100, 15'h0100, 1'b1);

    step(15'h0010, 15'h0010, 1'b0);
    step(15'h0000, 15'h0000, 1'b0);
    step(15'h0000, 15'h0000, 1'b0);

    // Async reset between edges while 0x0400 owns; pointer must restart at 0.
    step(15'h0400, 15'h0400, 1'b0);
    @(posedge clk);
    #7 rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    req   = 15'h0401;
    push(15'h0001, 1'b0);
    step(15'h0401, 15'h0001, 1'b0);
    step(15'h0400, 15'h0400, 1'b0);

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
